// File: rtl/mem_pkg.sv
// Shared definitions for the ram512 request/response initiator.
package mem_pkg;

  localparam int unsigned RAM_ADDR_W        = 9;
  localparam int unsigned RAM_DATA_W        = 32;
  localparam int unsigned ACCESS_CYCLES_MAX = 15;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RECOVER = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/ram512_initiator.sv
// Sequences a level-strobed ram512 access from a valid/ready request and
// returns the result on a valid/ready response channel.
module ram512_initiator
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = RAM_ADDR_W,
  parameter int unsigned DATA_W        = RAM_DATA_W,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read,
  output logic              mem_write
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > ACCESS_CYCLES_MAX) begin : g_bad_access_cycles
    $error("ram512_initiator: ACCESS_CYCLES must be in 1..15");
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wr_q;
  logic             accept_c;
  logic             last_strobe_c;

  assign accept_c      = (state == IDLE) && req_valid;
  assign last_strobe_c = (state == STROBE) && (cnt <= CNT_W'(1));

  // Next state and strobe down-counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) state_next = SETUP;
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = CNT_W'(ACCESS_CYCLES);
      end
      STROBE: begin
        if (last_strobe_c) begin
          state_next = RECOVER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are decoded from the next state so every strobe is a clean flop output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      mem_read  <= (state_next == STROBE) && !wr_q;
      mem_write <= (state_next == STROBE) && wr_q;
      if (accept_c) begin
        wr_q        <= req_write;
        mem_address <= req_addr;
        mem_data_in <= req_wdata;
      end
      // ram512 zeroes data_out once the strobe drops, so sample on the final strobe edge.
      if (last_strobe_c && !wr_q) begin
        rsp_rdata <= mem_data_out;
      end
      if ((state == RECOVER) && wr_q) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/ram512_initiator.md
# ram512_initiator

Sequencing initiator that drives the level-strobed `ram512` port from a clocked request/response handshake. It sits between the CPU datapath (MAR/MDR side) and `ram512`. It guarantees that address and write data are stable before any strobe, that `read` and `write` are never high together, and that read data is captured before the strobe drops. This matters because `ram512` zeroes `data_out` whenever neither strobe is asserted.

## Interface
Parameters:
- `ADDR_W`, default 9: RAM address width (512 words).
- `DATA_W`, default 32: word width.
- `ACCESS_CYCLES`, default 1: strobe-high cycles per access, range 1..15.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; accept occurs when `req_valid && req_ready`.
- `req_write` in 1: 1 means write, 0 means read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response available; held until taken.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out DATA_W: read data; 0 for write responses.
- `mem_address` out ADDR_W: to RAM `address`.
- `mem_data_in` out DATA_W: to RAM `data_in`.
- `mem_data_out` in DATA_W: from RAM `data_out`.
- `mem_read` out 1: to RAM `read`.
- `mem_write` out 1: to RAM `write`.

## Operation
- States: IDLE → SETUP → STROBE → RECOVER → RESP → IDLE.
- **IDLE**
  - `req_ready`=1.
  - On accept: latch `req_write`, `req_addr` and `req_wdata` into internal registers, then go to SETUP.
- **SETUP** (1 cycle)
  - `mem_address` and `mem_data_in` are driven from the latched values.
  - Both strobes are low.
- **STROBE** (ACCESS_CYCLES cycles, counted by a 4-bit down-counter)
  - Exactly one of `mem_read`/`mem_write` is high, selected by the latched `req_write`.
  - For reads, `mem_data_out` is registered into `rsp_rdata` at the edge that ends the last STROBE cycle.
- **RECOVER** (1 cycle)
  - Both strobes are low.
  - Address and data are still held.
- **RESP**
  - `rsp_valid`=1.
  - For a write, `rsp_rdata` is cleared to 0 on entry to RESP.
  - When `rsp_ready`=1, go to IDLE at the next edge.
- `mem_address` and `mem_data_in` change only on accept. They are stable from SETUP through RESP and remain stable in IDLE until the next accept.
- `mem_read` and `mem_write` are both registered outputs (glitch-free) and are never high simultaneously in any state.
- Only one transaction is in flight at a time. There is no pipelining, and `req_*` inputs are ignored outside IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0.
  - `rsp_rdata`=0.
  - `mem_address`=0.
  - `mem_data_in`=0.
  - `mem_read`=0.
  - `mem_write`=0.
  - Strobe counter: 0.
- Latency, with accept at edge E:
  - SETUP occupies E..E+1.
  - A strobe is high from E+1 through E+1+ACCESS_CYCLES.
  - Data is captured at E+1+ACCESS_CYCLES.
  - `rsp_valid` rises at E+2+ACCESS_CYCLES (E+3 at the default).
- Throughput: at least 4+ACCESS_CYCLES cycles per transaction, which is 5 at the default when `rsp_ready` is already high.
- `rsp_ready` held high before `rsp_valid` rises: the response is consumed in its first RESP cycle.
- `rsp_ready` low: the design stays in RESP indefinitely, and `rsp_rdata` is held constant.
- `req_valid` in the same cycle as a response handshake: not accepted until the following IDLE cycle.
- Reset asserted mid-transaction:
  - Strobes drop and state returns to IDLE asynchronously, immediately.
  - The pending response is discarded; no `rsp_valid` is produced after reset.
  - A write interrupted mid-strobe leaves RAM contents undefined at that address; this is a documented hazard.
- `ACCESS_CYCLES` outside 1..15 is an elaboration error (generate-time check).

## Structure
- Shared package `mem_pkg` holds:
  - The state enum (IDLE, SETUP, STROBE, RECOVER, RESP; 3-bit encoding).
  - `RAM_ADDR_W`=9 and `RAM_DATA_W`=32.
  - `ACCESS_CYCLES_MAX`=15.
- No sub-module. The strobe down-counter and FSM live in one always block, with output registers in a second always block.

## Test plan
The bench instantiates `ram512` with its initial image (word 66 = 57, word 56 = 34).

- **Read 66**: read with addr 66 → `rsp_valid` at accept+3, `rsp_rdata`=57; during access, `mem_read` is high for exactly 1 cycle and `mem_write`=0 throughout.
- **Write then read back**: write addr 100, data 0xDEADBEEF, then read 100 → write response has `rsp_rdata`=0; read response has `rsp_rdata`=0xDEADBEEF.
- **Backpressure**: read 56 with `rsp_ready` held low for 10 cycles → `rsp_valid` stays 1 with `rsp_rdata`=34 for all 10 cycles; `req_ready`=0 throughout; a second `req_valid` is not accepted until after the handshake.
- **Reset mid-strobe**: `reset_n` low during STROBE of a read → strobes 0, `rsp_valid` 0 and `req_ready` 1 in the same cycle; no response follows.
- **Wait states**: `ACCESS_CYCLES`=3, read 66 → `mem_read` high for 3 cycles, `rsp_valid` at accept+5, `rsp_rdata`=57.
- **Exclusion and stability**: 200 random read/write requests → assertion that `mem_read && mem_write` is never true, and `mem_address` never changes while either strobe is high.
